// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (read-only)
// and the data stage (read/write). Data wins contention and a streak counter forces a fetch grant.
module mem_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STREAK_W = $clog2(STARVE_LIM + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_reg,     state_next;
  logic                grant_d_reg,   grant_d_next;
  logic [STREAK_W-1:0] streak_reg,    streak_next;
  logic                mem_req_reg,   mem_req_next;
  logic                mem_we_reg,    mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg,  mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                i_ack_reg,     i_ack_next;
  logic                d_ack_reg,     d_ack_next;
  logic [DATA_W-1:0]   i_rdata_reg,   i_rdata_next;
  logic [DATA_W-1:0]   d_rdata_reg,   d_rdata_next;
  logic                pick_d;

  // Data wins unless the fetch side has been passed over STARVE_LIM times in a row.
  assign pick_d = d_req && !(i_req && (streak_reg == STREAK_MAX));

  always_comb begin
    state_next     = state_reg;
    grant_d_next   = grant_d_reg;
    streak_next    = streak_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    i_ack_next     = 1'b0;
    d_ack_next     = 1'b0;
    i_rdata_next   = i_rdata_reg;
    d_rdata_next   = d_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          grant_d_next = pick_d;
          mem_req_next = 1'b1;
          state_next   = ACCESS;
          if (pick_d) begin
            mem_we_next    = d_we;
            mem_addr_next  = d_addr;
            mem_wdata_next = d_wdata;
            if (!i_req)
              streak_next = '0;
            else if (streak_reg != STREAK_MAX)
              streak_next = streak_reg + STREAK_W'(1);
          end else begin
            mem_we_next    = 1'b0;
            mem_addr_next  = i_addr;
            mem_wdata_next = '0;
            streak_next    = '0;
          end
        end
      end

      ACCESS: begin
        if (mem_rdy) begin
          mem_req_next = 1'b0;
          state_next   = RESP;
          if (grant_d_reg) begin
            d_ack_next = 1'b1;
            if (!mem_we_reg)
              d_rdata_next = mem_rdata;
          end else begin
            i_ack_next   = 1'b1;
            i_rdata_next = mem_rdata;
          end
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_d_reg   <= 1'b0;
      streak_reg    <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      i_ack_reg     <= 1'b0;
      d_ack_reg     <= 1'b0;
      i_rdata_reg   <= '0;
      d_rdata_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      grant_d_reg   <= grant_d_next;
      streak_reg    <= streak_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      i_ack_reg     <= i_ack_next;
      d_ack_reg     <= d_ack_next;
      i_rdata_reg   <= i_rdata_next;
      d_rdata_reg   <= d_rdata_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign i_ack     = i_ack_reg;
  assign d_ack     = d_ack_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural memory with programmable wait states,
// outputs sampled on the falling edge.
module tb_mem_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rdy;
  logic [DATA_W-1:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  // memory model controls
  logic              auto_mem;
  int                waits;
  int                wait_cnt;
  logic              man_rdy;
  logic [DATA_W-1:0] man_rdata;
  logic [DATA_W-1:0] mem [0:255];

  int i_ack_cnt = 0;
  int d_ack_cnt = 0;
  int both_cnt  = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory answers after 'waits' extra cycles; writes return a junk word.
  always @(negedge clk) begin
    if (!auto_mem) begin
      mem_rdy   = man_rdy;
      mem_rdata = man_rdata;
      wait_cnt  = 0;
    end else if (mem_req && !mem_rdy) begin
      if (wait_cnt == waits) begin
        mem_rdy  = 1'b1;
        wait_cnt = 0;
        if (mem_we) begin
          mem[mem_addr[7:0]] = mem_wdata;
          mem_rdata = 16'hDEAD;
        end else begin
          mem_rdata = mem[mem_addr[7:0]];
        end
      end else begin
        mem_rdy  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_rdy  = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (i_ack) i_ack_cnt++;
    if (d_ack) d_ack_cnt++;
    if (i_ack && d_ack) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Counts falling edges until either ack is seen (bounded).
  task automatic wait_ack(input string tag, output int n, output logic got_i, output logic got_d);
    logic done;
    n = 0; got_i = 1'b0; got_d = 1'b0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      n++;
      if (i_ack || d_ack) begin
        got_i = i_ack;
        got_d = d_ack;
        done  = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_ack expected=ack", tag);
    end
  endtask

  int          n;
  logic        gi, gd;
  int          dcnt, icnt;
  logic [9:0]  order_obs;
  logic [9:0]  order_exp;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 16'(a * 16'h0101);
    mem[8'h10] = 16'h1234;
    auto_mem = 1'b1; waits = 0; wait_cnt = 0; man_rdy = 1'b0; man_rdata = '0;
    mem_rdy = 1'b0; mem_rdata = '0;

    // Reset with both requests pending
    rst = 1'b1;
    i_req = 1'b1; i_addr = 20'h00008;
    d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00005; d_wdata = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
    check("rst_mem_addr", {12'd0, mem_addr}, 32'd0);
    check("rst_rdata", {i_rdata, d_rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_mem_req", {31'd0, mem_req}, 32'd1);
    check("rel_d_first", {12'd0, mem_addr}, 32'h00005);
    wait_ack("rel_d", n, gi, gd);
    check("rel_d_ack", {30'd0, gi, gd}, 32'b01);
    check("rel_d_rdata", {16'd0, d_rdata}, 32'h0505);
    d_req = 1'b0;
    wait_ack("rel_i", n, gi, gd);
    check("rel_i_ack", {30'd0, gi, gd}, 32'b10);
    check("rel_i_lat", n, 32'd3);
    check("rel_i_rdata", {16'd0, i_rdata}, 32'h0808);
    i_req = 1'b0;

    // Single fetch, zero-wait
    @(negedge clk);
    dcnt = d_ack_cnt;
    i_addr = 20'h00010; i_req = 1'b1;
    @(negedge clk);
    check("f_mem_req", {31'd0, mem_req}, 32'd1);
    check("f_mem_addr", {12'd0, mem_addr}, 32'h00010);
    check("f_mem_we", {31'd0, mem_we}, 32'd0);
    wait_ack("f", n, gi, gd);
    check("f_ack", {30'd0, gi, gd}, 32'b10);
    check("f_lat", n, 32'd1);
    check("f_rdata", {16'd0, i_rdata}, 32'h1234);
    i_req = 1'b0;
    @(negedge clk);
    check("f_ack_pulse", {31'd0, i_ack}, 32'd0);
    check("f_no_d_ack", d_ack_cnt, dcnt);

    // D write then D read, two wait states
    waits = 2;
    d_addr = 20'h0003F; d_wdata = 16'hBEEF; d_we = 1'b1; d_req = 1'b1;
    @(negedge clk);
    check("w_mem_we", {31'd0, mem_we}, 32'd1);
    check("w_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    check("w_mem_addr", {12'd0, mem_addr}, 32'h0003F);
    wait_ack("w", n, gi, gd);
    check("w_ack", {30'd0, gi, gd}, 32'b01);
    check("w_lat", n, 32'd3);
    check("w_rdata_hold", {16'd0, d_rdata}, 32'h0505);
    d_we = 1'b0;
    wait_ack("r", n, gi, gd);
    check("r_ack", {30'd0, gi, gd}, 32'b01);
    check("r_period", n, 32'd5);
    check("r_rdata", {16'd0, d_rdata}, 32'hBEEF);
    d_req = 1'b0;

    // Starvation guard: both held, expect D,D,D,D,I x2 (1 = I grant)
    @(negedge clk);
    waits = 0;
    i_addr = 20'h00020; d_addr = 20'h00040; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    order_exp = 10'b1000010000;
    order_obs = '0;
    for (int g = 0; g < 10; g++) begin
      wait_ack("starve", n, gi, gd);
      order_obs[g] = gi;
      if (g > 0) check("starve_period", n, 32'd3);
      if (g == 9) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    check("starve_order", {22'd0, order_obs}, {22'd0, order_exp});
    check("starve_i_data", {16'd0, i_rdata}, 32'h2020);
    check("both_acks", both_cnt, 32'd0);

    // Reset during the second ACCESS cycle of a D read
    @(negedge clk);
    waits = 2;
    dcnt = d_ack_cnt;
    d_addr = 20'h0003F; d_we = 1'b0; d_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_mem_req", {31'd0, mem_req}, 32'd0);
    check("mr_rdata", {i_rdata, d_rdata}, 32'd0);
    rst = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
    check("mr_no_d_ack", d_ack_cnt, dcnt);
    i_addr = 20'h00010; i_req = 1'b1;
    wait_ack("mr_i", n, gi, gd);
    check("mr_i_ack", {30'd0, gi, gd}, 32'b10);
    check("mr_i_lat", n, 32'd4);
    check("mr_i_rdata", {16'd0, i_rdata}, 32'h1234);
    i_req = 1'b0;

    // Spurious mem_rdy in IDLE and RESP
    @(negedge clk);
    auto_mem = 1'b0;
    icnt = i_ack_cnt; dcnt = d_ack_cnt;
    man_rdy = 1'b1; man_rdata = 16'h5555;
    repeat (3) @(negedge clk);
    check("sp_idle_acks", i_ack_cnt + d_ack_cnt, icnt + dcnt);
    check("sp_idle_req", {31'd0, mem_req}, 32'd0);
    check("sp_idle_rdata", {i_rdata, d_rdata}, 32'h12340000);
    man_rdy = 1'b0;
    i_req = 1'b1; i_addr = 20'h00011;
    @(negedge clk);
    man_rdy = 1'b1; man_rdata = 16'hA5A5;
    @(negedge clk);
    check("sp_man_ack", {31'd0, i_ack}, 32'd1);
    check("sp_man_rdata", {16'd0, i_rdata}, 32'hA5A5);
    i_req = 1'b0; man_rdata = 16'h7777;
    @(negedge clk);
    check("sp_resp_ack", {30'd0, i_ack, d_ack}, 32'd0);
    check("sp_resp_rdata", {16'd0, i_rdata}, 32'hA5A5);
    check("sp_resp_req", {31'd0, mem_req}, 32'd0);
    man_rdy = 1'b0;
    @(negedge clk);
    auto_mem = 1'b1; waits = 0;
    d_addr = 20'h00040; d_we = 1'b0; d_req = 1'b1;
    wait_ack("sp_after", n, gi, gd);
    check("sp_after_ack", {30'd0, gi, gd}, 32'b01);
    check("sp_after_lat", n, 32'd2);
    check("sp_after_data", {16'd0, d_rdata}, 32'h4040);
    d_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one unified 16-bit instruction/data memory between the CPU fetch unit (read-only, port I) and the memory stage (read/write, port D). It sits between the pipeline and the memory, serialising accesses with a req/ack handshake toward each requester and a req/rdy handshake toward memory. Data accesses win contention, with a starvation guard so fetch always makes progress.

## Interface

- ADDR_W, 20, word address width
- DATA_W, 16, data word width
- STARVE_LIM, 4, max consecutive contended D grants before I is forced (>=1)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  ADDR_W  fetch address; stable while i_req
- i_ack  out  1  one-cycle pulse, fetch complete
- i_rdata  out  DATA_W  fetched word, valid with i_ack, held until next I ack
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  ADDR_W  data address; stable while d_req
- d_wdata  in  DATA_W  write data; stable while d_req
- d_ack  out  1  one-cycle pulse, data access complete
- d_rdata  out  DATA_W  read word, valid with d_ack on reads, held otherwise
- mem_req  out  1  memory access request, held until mem_rdy
- mem_we  out  1  memory write enable, qualified by mem_req
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdy  in  1  memory completion; mem_rdata valid this cycle for reads
- mem_rdata  in  DATA_W  memory read data

## Operation

- FSM states: IDLE, ACCESS, RESP. All outputs registered.
- IDLE: no req -> stay. Else choose winner, latch its addr/we/wdata (I: we=0, wdata=0) into mem_* registers, set mem_req=1, go ACCESS.
- Winner choice: only one req -> that one. Both -> D, unless streak counter == STARVE_LIM, then I.
- Streak counter (0..STARVE_LIM): D grant with i_req high -> increment (saturate); D grant with i_req low -> clear; any I grant -> clear.
- ACCESS: hold mem_req and mem_* stable. On mem_rdy: clear mem_req; if winner is I, load i_rdata=mem_rdata; if D read, load d_rdata=mem_rdata; D write leaves d_rdata unchanged; set winner's ack; go RESP.
- RESP: winner's ack high exactly this cycle; clear ack; go IDLE.
- Requester contract: req may drop or change address only at the edge after it samples ack high; req seen in the IDLE cycle after RESP is a new request.
- mem_rdy while not in ACCESS is ignored.

## Timing

- Reset (rst=1 at an edge): state IDLE; mem_req, mem_we, i_ack, d_ack = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; streak = 0.
- Reset mid-ACCESS abandons the access: mem_req low next cycle, no ack issued; memory must tolerate the dropped request.
- Req high in IDLE at edge N -> mem_req high from N+1. mem_rdy high at edge M -> ack high cycle M+1 (RESP), mem_req low from M+1. Earliest next mem_req: M+3.
- Zero-wait memory (mem_rdy in first ACCESS cycle): 3 cycles per access, request to ack = 2 cycles.
- Never both acks in the same cycle; at most one access outstanding.

## Test plan

- Reset: hold rst 2 cycles with both reqs high -> all outputs 0, no mem_req; release -> D granted first.
- Single fetch, zero-wait memory, i_addr=0x00010, mem_rdata=0x1234 -> mem_req 1 cycle after i_req, i_ack one cycle later with i_rdata=0x1234, d_ack never asserts.
- D write then D read to 0x0003F, wdata=0xBEEF, memory with 2 wait states -> mem_we=1 on write, d_ack after write with d_rdata unchanged, read returns 0xBEEF; each access 5 cycles.
- Starvation: i_req and d_req held continuously (D re-requests after each ack), STARVE_LIM=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Reset asserted in ACCESS cycle 2 of a D read -> no d_ack, mem_req low next cycle, d_rdata=0, subsequent I request served normally.
- Spurious mem_rdy in IDLE and RESP -> no ack, no rdata change, no state change.
